// File: rtl/dvv_sock_hub.sv
// N-channel transaction socket: per-channel FIFOs merged by a round-robin arbiter
// into one registered valid/ready stream tagged with the source channel.
module dvv_sock_hub #(
   parameter int DW    = 32,
   parameter int CH    = 4,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(CH),
   localparam int LW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic [CH*DW-1:0] in_data,
   input  logic [CH-1:0]    in_vld,
   output logic [CH-1:0]    in_rdy,
   output logic [DW-1:0]    out_data,
   output logic [CW-1:0]    out_ch,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [CH*LW-1:0] fill
);

   localparam int PW = LW - 1;

   logic [LW-1:0] r_cnt [CH];
   logic [PW-1:0] r_wp  [CH];
   logic [PW-1:0] r_rp  [CH];
   logic [DW-1:0] r_mem [CH][DEPTH];
   logic [CW-1:0] r_rr;
   logic [DW-1:0] r_out_data;
   logic [CW-1:0] r_out_ch;
   logic          r_out_vld;

   logic [CH-1:0] w_nempty;
   logic [CH-1:0] w_rdy;
   logic [CH-1:0] w_push;
   logic [CH-1:0] w_pop;
   logic [CW-1:0] w_scan [CH];
   logic [CW-1:0] w_grant;
   logic [CW-1:0] w_next;
   logic          w_load;

   genvar g;
   generate
      for (g = 0; g < CH; g++) begin : g_ch
         assign w_nempty[g]         = (r_cnt[g] != LW'(0));
         // A full channel refuses a push even when it is popped this cycle.
         assign w_rdy[g]            = (r_cnt[g] != LW'(DEPTH)) & ~flush;
         assign w_push[g]           = in_vld[g] & w_rdy[g];
         assign w_pop[g]            = w_load & (w_grant == CW'(g));
         assign fill[g*LW +: LW]    = r_cnt[g];
      end
   endgenerate

   assign in_rdy   = w_rdy;
   assign out_data = r_out_data;
   assign out_ch   = r_out_ch;
   assign out_vld  = r_out_vld;

   assign w_load = (~r_out_vld | out_rdy) & (|w_nempty) & ~flush;
   assign w_next = (w_grant == CW'(CH - 1)) ? CW'(0) : (w_grant + CW'(1));

   // Channel indices in scan order, starting at the round-robin pointer.
   always_comb begin
      for (int i = 0; i < CH; i++) begin
         w_scan[i] = CW'((int'(r_rr) + i) % CH);
      end
   end

   // Grant: first non-empty channel in scan order; later entries are overridden.
   always_comb begin
      w_grant = r_rr;
      for (int i = CH - 1; i >= 0; i--) begin
         w_grant = w_nempty[w_scan[i]] ? w_scan[i] : w_grant;
      end
   end

   // FIFO occupancy and read/write pointers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int c = 0; c < CH; c++) begin
            r_cnt[c] <= LW'(0);
            r_wp[c]  <= PW'(0);
            r_rp[c]  <= PW'(0);
         end
      end else if (flush) begin
         for (int c = 0; c < CH; c++) begin
            r_cnt[c] <= LW'(0);
            r_wp[c]  <= PW'(0);
            r_rp[c]  <= PW'(0);
         end
      end else begin
         for (int c = 0; c < CH; c++) begin
            if (w_push[c]) begin
               r_wp[c] <= r_wp[c] + PW'(1);
            end
            if (w_pop[c]) begin
               r_rp[c] <= r_rp[c] + PW'(1);
            end
            case ({w_push[c], w_pop[c]})
               2'b10:   r_cnt[c] <= r_cnt[c] + LW'(1);
               2'b01:   r_cnt[c] <= r_cnt[c] - LW'(1);
               default: r_cnt[c] <= r_cnt[c];
            endcase
         end
      end
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      for (int c = 0; c < CH; c++) begin
         if (w_push[c]) begin
            r_mem[c][r_wp[c]] <= in_data[c*DW +: DW];
         end
      end
   end

   // Output register and round-robin pointer; data and channel hold when not loading.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_vld  <= 1'b0;
         r_out_data <= DW'(0);
         r_out_ch   <= CW'(0);
         r_rr       <= CW'(0);
      end else if (flush) begin
         r_out_vld  <= 1'b0;
         r_rr       <= CW'(0);
      end else if (w_load) begin
         r_out_vld  <= 1'b1;
         r_out_data <= r_mem[w_grant][r_rp[w_grant]];
         r_out_ch   <= w_grant;
         r_rr       <= w_next;
      end else if (out_rdy) begin
         r_out_vld  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dvv_sock_hub.sv
// Randomized and directed bench for dvv_sock_hub against a queue-based reference model.
module tb_dvv_sock_hub;

   localparam int DW    = 32;
   localparam int CH    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 2;
   localparam int LW    = 3;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             flush = 1'b0;
   logic             out_rdy = 1'b0;
   logic [CH*DW-1:0] in_data = '0;
   logic [CH-1:0]    in_vld = '0;
   logic [CH-1:0]    in_rdy;
   logic [DW-1:0]    out_data;
   logic [CW-1:0]    out_ch;
   logic             out_vld;
   logic [CH*LW-1:0] fill;

   dvv_sock_hub #(.DW(DW), .CH(CH), .DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .flush(flush),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_data(out_data), .out_ch(out_ch), .out_vld(out_vld),
      .out_rdy(out_rdy), .fill(fill)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] q [CH][$];
   bit            m_vld;
   logic [DW-1:0] m_data;
   int            m_ch;
   int            m_rr;
   int            total = 0;
   int            bad = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) q[c].delete();
      m_vld  = 1'b0;
      m_data = '0;
      m_ch   = 0;
      m_rr   = 0;
   endfunction

   // One clock edge of the socket, expressed as queue operations.
   function automatic void model_edge();
      bit acc [CH];
      bit found;
      int gr;
      if (!resetn) begin
         model_reset();
         return;
      end
      if (flush) begin
         for (int c = 0; c < CH; c++) q[c].delete();
         m_vld = 1'b0;
         m_rr  = 0;
         return;
      end
      for (int c = 0; c < CH; c++) acc[c] = in_vld[c] && (q[c].size() < DEPTH);
      found = 1'b0;
      gr    = 0;
      if (!m_vld || out_rdy) begin
         for (int i = 0; i < CH; i++) begin
            int cc;
            cc = (m_rr + i) % CH;
            if (!found && q[cc].size() > 0) begin
               found = 1'b1;
               gr    = cc;
            end
         end
         if (found) begin
            m_data = q[gr].pop_front();
            m_ch   = gr;
            m_vld  = 1'b1;
            m_rr   = (gr + 1) % CH;
         end else begin
            m_vld = 1'b0;
         end
      end
      for (int c = 0; c < CH; c++) if (acc[c]) q[c].push_back(in_data[c*DW +: DW]);
   endfunction

   // Every cycle: DUT outputs against the model.
   always @(negedge clk) begin
      for (int c = 0; c < CH; c++) begin
         chk($sformatf("fill[%0d]", c), fill[c*LW +: LW], q[c].size());
         chk($sformatf("in_rdy[%0d]", c), in_rdy[c], (q[c].size() != DEPTH) && !flush);
      end
      chk("out_vld", out_vld, m_vld);
      chk("out_data", out_data, m_data);
      chk("out_ch", out_ch, m_ch);
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic flush_pulse();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   int w;
   int got;
   bit acc_prev [CH];

   initial begin
      model_reset();
      repeat (2) step();
      resetn = 1'b1;

      // Latency: one word on ch2
      out_rdy = 1'b1;
      in_vld = 4'b0100;
      in_data[2*DW +: DW] = 32'hA5;
      step();
      in_vld = 4'b0000;
      step();
      chk("lat_vld", out_vld, 1);
      chk("lat_data", out_data, 32'hA5);
      chk("lat_ch", out_ch, 2);
      step();
      chk("lat_drain", out_vld, 0);

      // Full: seven offers on ch0 with consumer stalled
      out_rdy = 1'b0;
      w = 1;
      for (int n = 0; n < 7; n++) begin
         in_vld = 4'b0001;
         in_data[DW-1:0] = w;
         if (in_rdy[0]) w++;
         step();
      end
      chk("full_accepted", w - 1, 5);
      chk("full_rdy", in_rdy[0], 0);
      chk("full_fill", fill[LW-1:0], 4);
      out_rdy = 1'b1;
      got = 0;
      for (int n = 0; n < 40 && got < 7; n++) begin
         if (w <= 7) begin
            in_vld = 4'b0001;
            in_data[DW-1:0] = w;
         end else begin
            in_vld = 4'b0000;
         end
         if (in_rdy[0] && in_vld[0]) w++;
         if (out_vld) begin
            chk("full_order", out_data, got + 1);
            got++;
         end
         step();
      end
      chk("full_count", got, 7);
      in_vld = 4'b0000;
      step();

      // Round-robin: two words per channel, then free-running consumer
      flush_pulse();
      out_rdy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_vld = 4'b1111;
         for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 32'h100 * c + k;
         step();
      end
      in_vld = 4'b0000;
      out_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("rr_vld", out_vld, 1);
         chk("rr_ch", out_ch, k % 4);
         chk("rr_data", out_data, 32'h100 * (k % 4) + k / 4);
         step();
      end

      // Back-pressure: head of ch1 held while consumer stalls
      flush_pulse();
      out_rdy = 1'b0;
      in_vld = 4'b0010;
      in_data[DW +: DW] = 32'h1234;
      step();
      in_data[DW +: DW] = 32'h5555;
      step();
      in_vld = 4'b0000;
      for (int k = 0; k < 3; k++) begin
         chk("bp_data", out_data, 32'h1234);
         chk("bp_ch", out_ch, 1);
         chk("bp_fill", fill[LW +: LW], 1);
         step();
      end
      out_rdy = 1'b1;
      step();
      chk("bp_next", out_data, 32'h5555);
      step();

      // Flush with a simultaneous push on ch3
      flush_pulse();
      out_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_vld = 4'b1111;
         for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 32'h2000 + 32'h10 * c + k;
         step();
      end
      flush = 1'b1;
      in_vld = 4'b1000;
      in_data[3*DW +: DW] = 32'hDEAD;
      step();
      flush = 1'b0;
      in_vld = 4'b0000;
      chk("fl_fill", fill, 0);
      chk("fl_vld", out_vld, 0);
      in_vld = 4'b1111;
      out_rdy = 1'b1;
      step();
      in_vld = 4'b0000;
      step();
      chk("fl_rr_restart", out_ch, 0);
      repeat (5) step();

      // Reset mid-stream with three words queued
      out_rdy = 1'b0;
      in_vld = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         in_data[DW-1:0] = 32'h300 + k;
         step();
      end
      in_vld = 4'b0000;
      chk("rst_pre_fill", fill[LW-1:0], 3);
      resetn = 1'b0;
      model_reset();
      #1;
      chk("rst_vld", out_vld, 0);
      chk("rst_fill", fill, 0);
      step();
      step();
      resetn = 1'b1;
      #1;
      chk("rst_rdy", in_rdy, 4'b1111);

      // Random traffic honouring the source hold rule
      for (int n = 0; n < 2000; n++) begin
         for (int c = 0; c < CH; c++) begin
            if (!(in_vld[c] && !acc_prev[c])) begin
               in_vld[c] = ($urandom_range(0, 99) < 55);
               in_data[c*DW +: DW] = $urandom();
            end
         end
         out_rdy = (n < 1000) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 30);
         flush = ($urandom_range(0, 99) < 3);
         for (int c = 0; c < CH; c++) acc_prev[c] = in_vld[c] && in_rdy[c];
         step();
      end
      in_vld = 4'b0000;
      flush = 1'b0;
      out_rdy = 1'b1;
      repeat (30) step();
      chk("drain_empty", fill, 0);
      chk("drain_vld", out_vld, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
